// File: rtl/ofs_plat_hssi_chan_idle_seq.sv
// Multi-channel HSSI parking sequencer. Each channel walks its transceiver through the
// analog reset, TX digital reset, RX lock wait and RX digital reset steps, then streams a
// constant idle word so the link partner sees a quiet, trained link.
module ofs_plat_hssi_chan_idle_seq #(
  parameter int unsigned                  NUM_CHANNELS        = 4,
  parameter int unsigned                  DATA_WIDTH          = 64,
  parameter int unsigned                  CTRL_WIDTH          = 8,
  parameter int unsigned                  ANALOG_RST_CYCLES   = 16,
  parameter int unsigned                  DIGITAL_RST_CYCLES  = 32,
  parameter int unsigned                  LOCK_TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0]        IDLE_DATA           = 64'h0707_0707_0707_0707,
  parameter logic [CTRL_WIDTH-1:0]        IDLE_CTRL           = 8'hFF
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable_i,
  input  logic                               err_clear_i,
  input  logic [NUM_CHANNELS-1:0]            tx_cal_busy_i,
  input  logic [NUM_CHANNELS-1:0]            rx_cal_busy_i,
  input  logic [NUM_CHANNELS-1:0]            rx_is_lockedtodata_i,
  output logic [NUM_CHANNELS-1:0]            tx_analogreset_o,
  output logic [NUM_CHANNELS-1:0]            rx_analogreset_o,
  output logic [NUM_CHANNELS-1:0]            tx_digitalreset_o,
  output logic [NUM_CHANNELS-1:0]            rx_digitalreset_o,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] tx_parallel_data_o,
  output logic [NUM_CHANNELS*CTRL_WIDTH-1:0] tx_control_o,
  output logic [NUM_CHANNELS-1:0]            tx_enh_data_valid_o,
  output logic [NUM_CHANNELS-1:0]            rx_enh_fifo_rd_en_o,
  output logic [NUM_CHANNELS-1:0]            rx_seriallpbken_o,
  output logic [NUM_CHANNELS-1:0]            rx_set_locktoref_o,
  output logic [NUM_CHANNELS-1:0]            rx_set_locktodata_o,
  output logic                               init_start_o,
  output logic                               prmgmt_fatal_err_o,
  output logic [31:0]                        prmgmt_dout_o,
  output logic [NUM_CHANNELS-1:0]            chan_ready_o,
  output logic [NUM_CHANNELS-1:0]            timeout_err_o
);

  localparam int unsigned MaxAd = (ANALOG_RST_CYCLES > DIGITAL_RST_CYCLES) ?
                                  ANALOG_RST_CYCLES : DIGITAL_RST_CYCLES;
  localparam int unsigned MaxCycles = (MaxAd > LOCK_TIMEOUT_CYCLES) ? MaxAd : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] AnalogLoad  = CntW'(ANALOG_RST_CYCLES - 1);
  localparam logic [CntW-1:0] DigitalLoad = CntW'(DIGITAL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] LockLoad    = CntW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StRstAll,
    StAnalog,
    StTxDig,
    StRxLock,
    StRxDig,
    StReady
  } state_e;

  // Unused transceiver features are parked low.
  assign rx_seriallpbken_o   = '0;
  assign rx_set_locktoref_o  = '0;
  assign rx_set_locktodata_o = '0;
  assign init_start_o        = 1'b0;
  assign prmgmt_fatal_err_o  = 1'b0;
  assign prmgmt_dout_o       = '0;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            err_set;
    logic            cal_busy;
    logic            locked;
    logic            cnt_zero;

    logic            tx_ana_rst, rx_ana_rst, tx_dig_rst, rx_dig_rst;
    logic            tx_on, ready;

    assign cal_busy = tx_cal_busy_i[i] | rx_cal_busy_i[i];
    assign locked   = rx_is_lockedtodata_i[i];
    assign cnt_zero = (cnt_q == '0);

    // Next-state, counter reload and timeout detection.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_zero ? cnt_q : cnt_q - CntW'(1);
      err_set = 1'b0;
      // Dropping enable or a calibration restart aborts bring-up from any active state.
      if ((state_q != StRstAll) && (!enable_i || cal_busy)) begin
        state_d = StRstAll;
      end else begin
        case (state_q)
          StRstAll: begin
            if (enable_i && !cal_busy) begin
              state_d = StAnalog;
              cnt_d   = AnalogLoad;
            end
          end
          StAnalog: begin
            if (cnt_zero) begin
              state_d = StTxDig;
              cnt_d   = DigitalLoad;
            end
          end
          StTxDig: begin
            if (cnt_zero) begin
              state_d = StRxLock;
              cnt_d   = LockLoad;
            end
          end
          StRxLock: begin
            // Lock takes precedence over a coincident timeout.
            if (locked) begin
              state_d = StRxDig;
              cnt_d   = DigitalLoad;
            end else if (cnt_zero) begin
              state_d = StRstAll;
              err_set = 1'b1;
            end
          end
          StRxDig: begin
            if (!locked) begin
              state_d = StRxLock;
              cnt_d   = LockLoad;
            end else if (cnt_zero) begin
              state_d = StReady;
            end
          end
          StReady: begin
            if (!locked) state_d = StRstAll;
          end
          default: state_d = StRstAll;
        endcase
      end
    end

    // Sticky timeout flag; a new timeout beats a coincident clear.
    always_comb begin
      err_d = err_q;
      if (err_set) begin
        err_d = 1'b1;
      end else if (err_clear_i) begin
        err_d = 1'b0;
      end
    end

    // Channel state, counter and error flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= StRstAll;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        err_q   <= err_d;
      end
    end

    // Output decode from the registered state.
    always_comb begin
      tx_ana_rst = 1'b1;
      rx_ana_rst = 1'b1;
      tx_dig_rst = 1'b1;
      rx_dig_rst = 1'b1;
      tx_on      = 1'b0;
      ready      = 1'b0;
      case (state_q)
        StTxDig: begin
          tx_ana_rst = 1'b0;
          rx_ana_rst = 1'b0;
        end
        StRxLock, StRxDig: begin
          tx_ana_rst = 1'b0;
          rx_ana_rst = 1'b0;
          tx_dig_rst = 1'b0;
          tx_on      = 1'b1;
        end
        StReady: begin
          tx_ana_rst = 1'b0;
          rx_ana_rst = 1'b0;
          tx_dig_rst = 1'b0;
          rx_dig_rst = 1'b0;
          tx_on      = 1'b1;
          ready      = 1'b1;
        end
        default: ;
      endcase
    end

    assign tx_analogreset_o[i]    = tx_ana_rst;
    assign rx_analogreset_o[i]    = rx_ana_rst;
    assign tx_digitalreset_o[i]   = tx_dig_rst;
    assign rx_digitalreset_o[i]   = rx_dig_rst;
    assign tx_enh_data_valid_o[i] = tx_on;
    assign rx_enh_fifo_rd_en_o[i] = ready;
    assign chan_ready_o[i]        = ready;
    assign timeout_err_o[i]       = err_q;
    assign tx_parallel_data_o[i*DATA_WIDTH +: DATA_WIDTH] = tx_on ? IDLE_DATA : '0;
    assign tx_control_o[i*CTRL_WIDTH +: CTRL_WIDTH]       = tx_on ? IDLE_CTRL : '0;
  end

endmodule

// File: tb/tb_ofs_plat_hssi_chan_idle_seq.sv
// Directed bench for the HSSI parking sequencer with default parameters.
module tb_ofs_plat_hssi_chan_idle_seq;

  localparam logic [63:0] Idle = 64'h0707_0707_0707_0707;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         err_clear;
  logic [3:0]   tx_cal_busy, rx_cal_busy, lock;
  logic [3:0]   tx_analogreset, rx_analogreset, tx_digitalreset, rx_digitalreset;
  logic [255:0] tx_parallel_data;
  logic [31:0]  tx_control;
  logic [3:0]   tx_enh_data_valid, rx_enh_fifo_rd_en;
  logic [3:0]   rx_seriallpbken, rx_set_locktoref, rx_set_locktodata;
  logic         init_start, prmgmt_fatal_err;
  logic [31:0]  prmgmt_dout;
  logic [3:0]   chan_ready, timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int e0       = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ofs_plat_hssi_chan_idle_seq dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .enable_i             (enable),
    .err_clear_i          (err_clear),
    .tx_cal_busy_i        (tx_cal_busy),
    .rx_cal_busy_i        (rx_cal_busy),
    .rx_is_lockedtodata_i (lock),
    .tx_analogreset_o     (tx_analogreset),
    .rx_analogreset_o     (rx_analogreset),
    .tx_digitalreset_o    (tx_digitalreset),
    .rx_digitalreset_o    (rx_digitalreset),
    .tx_parallel_data_o   (tx_parallel_data),
    .tx_control_o         (tx_control),
    .tx_enh_data_valid_o  (tx_enh_data_valid),
    .rx_enh_fifo_rd_en_o  (rx_enh_fifo_rd_en),
    .rx_seriallpbken_o    (rx_seriallpbken),
    .rx_set_locktoref_o   (rx_set_locktoref),
    .rx_set_locktodata_o  (rx_set_locktodata),
    .init_start_o         (init_start),
    .prmgmt_fatal_err_o   (prmgmt_fatal_err),
    .prmgmt_dout_o        (prmgmt_dout),
    .chan_ready_o         (chan_ready),
    .timeout_err_o        (timeout_err)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (edge E0+%0d)", tag, got, exp, cyc - e0);
    end
  endtask

  // Advance to just after edge E0+k.
  task automatic goto(input int k);
    if (cyc > e0 + k) check_eq("goto_overrun", 256'(cyc), 256'(e0 + k));
    while (cyc < e0 + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_txana"}, 256'(tx_analogreset), 256'hF);
    check_eq({tag, "_rxana"}, 256'(rx_analogreset), 256'hF);
    check_eq({tag, "_txdig"}, 256'(tx_digitalreset), 256'hF);
    check_eq({tag, "_rxdig"}, 256'(rx_digitalreset), 256'hF);
    check_eq({tag, "_data"}, tx_parallel_data, 256'h0);
    check_eq({tag, "_ctrl"}, 256'(tx_control), 256'h0);
    check_eq({tag, "_valid"}, 256'(tx_enh_data_valid), 256'h0);
    check_eq({tag, "_rden"}, 256'(rx_enh_fifo_rd_en), 256'h0);
    check_eq({tag, "_ready"}, 256'(chan_ready), 256'h0);
    check_eq({tag, "_terr"}, 256'(timeout_err), 256'h0);
  endtask

  task automatic check_consts(input string tag);
    check_eq({tag, "_const"}, {rx_seriallpbken, rx_set_locktoref, rx_set_locktodata,
                               init_start, prmgmt_fatal_err, prmgmt_dout}, 256'h0);
  endtask

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b0;
    err_clear   = 1'b0;
    tx_cal_busy = 4'b1000;  // channel 3 held in calibration
    rx_cal_busy = 4'b0000;
    lock        = 4'b1011;  // channel 2 never locks at first
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    check_consts("por");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("idle_disabled", 256'(tx_analogreset), 256'hF);

    enable = 1'b1;
    e0 = cyc + 1;

    goto(15);  check_eq("ana_hold", 256'(tx_analogreset), 256'hF);
    goto(16);  check_eq("ana_fall_tx", 256'(tx_analogreset), 256'b1000);
               check_eq("ana_fall_rx", 256'(rx_analogreset), 256'b1000);
               check_eq("txdig_hold16", 256'(tx_digitalreset), 256'hF);
    goto(47);  check_eq("txdig_hold", 256'(tx_digitalreset), 256'hF);
               check_eq("valid_off", 256'(tx_enh_data_valid), 256'h0);
    goto(48);  check_eq("txdig_fall", 256'(tx_digitalreset), 256'b1000);
               check_eq("valid_on", 256'(tx_enh_data_valid), 256'b0111);
               check_eq("idle_data", tx_parallel_data, {64'h0, Idle, Idle, Idle});
               check_eq("idle_ctrl", 256'(tx_control), 256'h00FF_FFFF);
    goto(80);  check_eq("ready_early", 256'(chan_ready), 256'h0);
    goto(81);  check_eq("ready_rise", 256'(chan_ready), 256'b0011);
               check_eq("rxdig_fall", 256'(rx_digitalreset), 256'b1100);
               check_eq("rden", 256'(rx_enh_fifo_rd_en), 256'b0011);
               check_eq("cal_hold3", 256'(tx_analogreset), 256'b1000);
    tx_cal_busy = 4'b0000;  // channel 3 starts at E0+82

    goto(162); check_eq("ch3_early", 256'(chan_ready), 256'b0011);
    goto(163); check_eq("ch3_ready", 256'(chan_ready), 256'b1011);
    lock = 4'b1001;         // channel 1 loses lock for one cycle
    goto(164); check_eq("ch1_drop_rdy", 256'(chan_ready), 256'b1001);
               check_eq("ch1_drop_ana", 256'(tx_analogreset), 256'b0010);
               check_eq("ch1_drop_rxd", 256'(rx_digitalreset), 256'b0110);
               check_eq("ch1_drop_vld", 256'(tx_enh_data_valid), 256'b1101);
    lock = 4'b1011;
    goto(245); check_eq("ch1_early", 256'(chan_ready), 256'b1001);
    goto(246); check_eq("ch1_ready", 256'(chan_ready), 256'b1011);

    goto(1071); check_eq("terr_pre", 256'(timeout_err), 256'h0);
    err_clear = 1'b1;       // coincides with the timeout: set must win
    goto(1072); check_eq("terr_set", 256'(timeout_err), 256'b0100);
                check_eq("terr_rst", 256'(tx_analogreset), 256'b0100);
    err_clear = 1'b0;
    goto(1073); check_eq("retry_ana", 256'(tx_analogreset), 256'b0100);
                check_eq("terr_sticky", 256'(timeout_err), 256'b0100);
    err_clear = 1'b1;
    goto(1074); check_eq("terr_clr", 256'(timeout_err), 256'h0);
    err_clear = 1'b0;

    // Channel 2 retry: ANALOG at 1073, TX_DIG at 1089, RX_LOCK at 1121, timeout edge 2145.
    goto(1121); check_eq("ch2_rxlock", 256'(tx_digitalreset), 256'h0);
    goto(2144); check_eq("ch2_wait", 256'(rx_digitalreset), 256'b0100);
    lock = 4'b1111;         // lock arrives on the counter-zero edge
    goto(2145); check_eq("race_terr", 256'(timeout_err), 256'h0);
                check_eq("race_ana", 256'(tx_analogreset), 256'h0);
                check_eq("race_rxd", 256'(rx_digitalreset), 256'b0100);
    goto(2176); check_eq("ch2_early", 256'(chan_ready), 256'b1011);
    goto(2177); check_eq("ch2_ready", 256'(chan_ready), 256'hF);
                check_eq("all_data", tx_parallel_data, {Idle, Idle, Idle, Idle});
                check_consts("run");

    enable = 1'b0;
    goto(2178); check_eq("dis_txana", 256'(tx_analogreset), 256'hF);
                check_eq("dis_txdig", 256'(tx_digitalreset), 256'hF);
                check_eq("dis_rxdig", 256'(rx_digitalreset), 256'hF);
                check_eq("dis_ready", 256'(chan_ready), 256'h0);
                check_eq("dis_valid", 256'(tx_enh_data_valid), 256'h0);
                check_eq("dis_data", tx_parallel_data, 256'h0);
                check_eq("dis_terr", 256'(timeout_err), 256'h0);

    enable = 1'b1;          // restart at E0+2179; TX_DIG from E0+2195
    goto(2200); check_eq("mid_txana", 256'(tx_analogreset), 256'h0);
                check_eq("mid_txdig", 256'(tx_digitalreset), 256'hF);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async");
    check_consts("async");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
